alu_cc_seq: RTL and testbench

ALU_CC_SEQ -- requirements
Module: alu_cc_seq

---
 rtl/alu_cc_seq.sv | 215 +++++++++++++++++++++
 tb/tb_alu_cc_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cc_seq.sv
`timescale 1ns/1ps
// alu_cc_seq: sequential ALU that keeps condition codes between operations.
// One request is accepted in IDLE. Add, sub, and, xor and illegal ops finish
// in one cycle. Shifts, when enabled, move one bit position per cycle.
// The result is then held in HOLD until the consumer takes it.
//
// Build option: define ALU_CC_SEQ_SHIFT_EN to enable shl/sar (ops 100/101).
// Without it those ops report illegal, and the shift datapath is not built.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   request handshake (in_ready only in IDLE)
//   op, a, b, shamt      opcode, operands, shift count
//   set_cc               request updates zf/sf/of
//   out_valid, out_ready result handshake
//   result, cout         registered result and carry/shifted-out bit
//   zf, sf, of           condition codes
//   illegal              held result belongs to an illegal/disabled op
module alu_cc_seq #(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    input  logic             set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             zf_q, zf_d, sf_q, sf_d, of_q, of_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH:0]   sum_ext;
    logic             of_calc;
    logic             upd_flags;

`ifdef ALU_CC_SEQ_SHIFT_EN
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SAR = 3'b101;

    logic [SHW-1:0] cnt_q, cnt_d;
    logic           sar_q, sar_d;
    logic           set_cc_q, set_cc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            sar_q    <= 1'b0;
            set_cc_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sar_q    <= sar_d;
            set_cc_q <= set_cc_d;
        end
    end
`else
    logic unused_shamt;
    assign unused_shamt = ^shamt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            result_q  <= '0;
            cout_q    <= 1'b0;
            zf_q      <= 1'b1;
            sf_q      <= 1'b0;
            of_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            zf_q      <= zf_d;
            sf_q      <= sf_d;
            of_q      <= of_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        cout_d    = cout_q;
        illegal_d = illegal_q;
        zf_d      = zf_q;
        sf_d      = sf_q;
        of_d      = of_q;
        sum_ext   = '0;
        of_calc   = 1'b0;
        upd_flags = 1'b0;
`ifdef ALU_CC_SEQ_SHIFT_EN
        cnt_d     = cnt_q;
        sar_d     = sar_q;
        set_cc_d  = set_cc_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = HOLD;
                    illegal_d = 1'b0;
                    cout_d    = 1'b0;
                    case (op)
                        OP_ADD: begin
                            sum_ext   = {1'b0, a} + {1'b0, b};
                            result_d  = sum_ext[WIDTH-1:0];
                            cout_d    = sum_ext[WIDTH];
                            of_calc   = (a[WIDTH-1] == b[WIDTH-1]) &&
                                        (sum_ext[WIDTH-1] != a[WIDTH-1]);
                            upd_flags = set_cc;
                        end
                        OP_SUB: begin
                            // a + ~b + 1 so cout is the no-borrow carry
                            sum_ext   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                            result_d  = sum_ext[WIDTH-1:0];
                            cout_d    = sum_ext[WIDTH];
                            of_calc   = (a[WIDTH-1] != b[WIDTH-1]) &&
                                        (sum_ext[WIDTH-1] != a[WIDTH-1]);
                            upd_flags = set_cc;
                        end
                        OP_AND: begin
                            result_d  = a & b;
                            upd_flags = set_cc;
                        end
                        OP_XOR: begin
                            result_d  = a ^ b;
                            upd_flags = set_cc;
                        end
`ifdef ALU_CC_SEQ_SHIFT_EN
                        OP_SHL, OP_SAR: begin
                            result_d = a;
                            if (shamt == '0) begin
                                upd_flags = set_cc;
                            end else begin
                                state_d  = SHIFT;
                                cnt_d    = shamt;
                                sar_d    = (op == OP_SAR);
                                set_cc_d = set_cc;
                            end
                        end
`endif
                        default: begin
                            result_d  = '0;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
`ifdef ALU_CC_SEQ_SHIFT_EN
            SHIFT: begin
                if (sar_q) begin
                    result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
                    cout_d   = result_q[0];
                end else begin
                    result_d = {result_q[WIDTH-2:0], 1'b0};
                    cout_d   = result_q[WIDTH-1];
                end
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d   = HOLD;
                    upd_flags = set_cc_q;
                end
            end
`endif
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flags only move on the edge that enters HOLD with a legal op.
        if (upd_flags) begin
            zf_d = (result_d == '0);
            sf_d = result_d[WIDTH-1];
            of_d = of_calc;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign result    = result_q;
    assign cout      = cout_q;
    assign zf        = zf_q;
    assign sf        = sf_q;
    assign of        = of_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_cc_seq.sv
`timescale 1ns/1ps
module tb_alu_cc_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 64-bit instance
    logic        rst64, iv64, ir64, cc64, ov64, or64, co64, zf64, sf64, of64, il64;
    logic [2:0]  op64;
    logic [63:0] a64, b64, res64;
    logic [5:0]  sh64;

    // 8-bit instance
    logic        rst8, iv8, ir8, cc8, ov8, or8, co8, zf8, sf8, of8, il8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, res8;
    logic [2:0]  sh8;

    alu_cc_seq #(.WIDTH(64)) u64 (
        .clk(clk), .rst(rst64), .in_valid(iv64), .in_ready(ir64), .op(op64),
        .a(a64), .b(b64), .shamt(sh64), .set_cc(cc64), .out_valid(ov64),
        .out_ready(or64), .result(res64), .cout(co64), .zf(zf64), .sf(sf64),
        .of(of64), .illegal(il64)
    );

    alu_cc_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .op(op8),
        .a(a8), .b(b8), .shamt(sh8), .set_cc(cc8), .out_valid(ov8),
        .out_ready(or8), .result(res8), .cout(co8), .zf(zf8), .sf(sf8),
        .of(of8), .illegal(il8)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
        else n_pass++;
    endtask

    // Drive one request, then count edges (accept edge = 1) until out_valid.
    task automatic issue64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic cc, output int lat);
        @(negedge clk);
        op64 = op; a64 = a; b64 = b; sh64 = '0; cc64 = cc; iv64 = 1'b1;
        @(posedge clk); #1;
        iv64 = 1'b0;
        lat = 1;
        while (!ov64 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] sh, input logic cc, output int lat);
        @(negedge clk);
        op8 = op; a8 = a; b8 = b; sh8 = sh; cc8 = cc; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release64(input string name);
        @(negedge clk); or64 = 1'b1;
        @(posedge clk); #1; or64 = 1'b0;
        chk1({name, "_ov_drop"}, ov64, 1'b0);
        chk1({name, "_ir_back"}, ir64, 1'b1);
    endtask

    task automatic release8(input string name);
        @(negedge clk); or8 = 1'b1;
        @(posedge clk); #1; or8 = 1'b0;
        chk1({name, "_ov_drop"}, ov8, 1'b0);
    endtask

    task automatic chk8(input string name, input logic [7:0] r, input logic co,
                        input logic z, input logic s, input logic o, input logic il);
        chk({name, "_res"}, 64'(res8), 64'(r));
        chk1({name, "_cout"}, co8, co);
        chk1({name, "_zf"}, zf8, z);
        chk1({name, "_sf"}, sf8, s);
        chk1({name, "_of"}, of8, o);
        chk1({name, "_ill"}, il8, il);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic        cc;
        logic [63:0] res;
        logic        co, z, s, o, il;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int lat;

        // Flags carry over between rows, so each row's expectations assume
        // the rows above it have run in order from reset (zf=1, sf=0, of=0).
        vecs[0]  = '{3'b000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{3'b001, 64'h5, 64'h5, 1'b1, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'b011, 64'h3, 64'h1, 1'b0, 64'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'b001, 64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'b001, 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{3'b010, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b0, 64'hF000_F000_F000_F000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{3'b010, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b110, 64'h1234, 64'h1, 1'b1, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{3'b000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{3'b111, 64'hFFFF, 64'hFFFF, 1'b1, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0FFF_FFFF_FFFF_FFFF, 1'b1, 64'hF000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        rst64 = 1'b1; rst8 = 1'b1;
        iv64 = 1'b0; op64 = '0; a64 = '0; b64 = '0; sh64 = '0; cc64 = 1'b0; or64 = 1'b0;
        iv8  = 1'b0; op8  = '0; a8  = '0; b8  = '0; sh8  = '0; cc8  = 1'b0; or8  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst64 = 1'b0; rst8 = 1'b0;
        @(posedge clk); #1;

        chk("rst_res", res64, 64'h0);
        chk1("rst_cout", co64, 1'b0);
        chk1("rst_zf", zf64, 1'b1);
        chk1("rst_sf", sf64, 1'b0);
        chk1("rst_of", of64, 1'b0);
        chk1("rst_ill", il64, 1'b0);
        chk1("rst_ov", ov64, 1'b0);
        chk1("rst_ir", ir64, 1'b1);

        for (int i = 0; i < 12; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            issue64(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cc, lat);
            chk({nm, "_lat"}, 64'(lat), 64'd1);
            chk({nm, "_res"}, res64, vecs[i].res);
            chk1({nm, "_cout"}, co64, vecs[i].co);
            chk1({nm, "_zf"}, zf64, vecs[i].z);
            chk1({nm, "_sf"}, sf64, vecs[i].s);
            chk1({nm, "_of"}, of64, vecs[i].o);
            chk1({nm, "_ill"}, il64, vecs[i].il);
            release64(nm);
        end

        // Stall in HOLD while a competing request is offered; it must be ignored.
        issue64(3'b000, 64'h1, 64'h2, 1'b0, lat);
        chk("stall_lat", 64'(lat), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            iv64 = 1'b1; op64 = 3'b011; a64 = 64'hFF; b64 = 64'h0;
            @(posedge clk); #1;
            chk1($sformatf("stall%0d_ov", k), ov64, 1'b1);
            chk($sformatf("stall%0d_res", k), res64, 64'h3);
            chk1($sformatf("stall%0d_ir", k), ir64, 1'b0);
        end
        @(negedge clk); iv64 = 1'b0;
        release64("stall");
        chk("stall_res_after", res64, 64'h3);

        // 8-bit instance: set a non-reset flag state first.
        issue8(3'b000, 8'h7F, 8'h01, 3'd0, 1'b1, lat);
        chk("a8_lat", 64'(lat), 64'd1);
        chk8("a8", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        release8("a8");

`ifdef ALU_CC_SEQ_SHIFT_EN
        issue8(3'b101, 8'h90, 8'h00, 3'd3, 1'b1, lat);
        chk("sar3_lat", 64'(lat), 64'd4);
        chk8("sar3", 8'hF2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        release8("sar3");

        issue8(3'b101, 8'h90, 8'h00, 3'd0, 1'b0, lat);
        chk("sar0_lat", 64'(lat), 64'd1);
        chk8("sar0", 8'h90, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        release8("sar0");

        issue8(3'b100, 8'h80, 8'h00, 3'd1, 1'b1, lat);
        chk("shl80_lat", 64'(lat), 64'd2);
        chk8("shl80", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        release8("shl80");

        issue8(3'b100, 8'h81, 8'h00, 3'd1, 1'b1, lat);
        chk("shl81_lat", 64'(lat), 64'd2);
        chk8("shl81", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        release8("shl81");

        // Reset in the middle of a long shift.
        @(negedge clk);
        op8 = 3'b100; a8 = 8'h01; sh8 = 3'd7; cc8 = 1'b1; iv8 = 1'b1;
        @(posedge clk); #1; iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("midshift_ov", ov8, 1'b0);
        rst8 = 1'b1;
        #1;
        chk1("rstshift_ov", ov8, 1'b0);
        chk("rstshift_res", 64'(res8), 64'h0);
        chk1("rstshift_zf", zf8, 1'b1);
        chk1("rstshift_ir", ir8, 1'b1);
        @(negedge clk); rst8 = 1'b0;
        issue8(3'b000, 8'h7F, 8'h01, 3'd0, 1'b1, lat);
        chk("postrst_lat", 64'(lat), 64'd1);
        chk8("postrst", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        release8("postrst");
`else
        issue8(3'b100, 8'hFF, 8'h00, 3'd2, 1'b1, lat);
        chk("shl_dis_lat", 64'(lat), 64'd1);
        chk8("shl_dis", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        release8("shl_dis");

        issue8(3'b101, 8'h81, 8'h00, 3'd3, 1'b1, lat);
        chk("sar_dis_lat", 64'(lat), 64'd1);
        chk8("sar_dis", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        release8("sar_dis");

        issue8(3'b000, 8'h01, 8'h02, 3'd0, 1'b0, lat);
        chk("clr_ill_lat", 64'(lat), 64'd1);
        chk8("clr_ill", 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        release8("clr_ill");
`endif

        // Reset while a result is held.
        issue8(3'b000, 8'h10, 8'h20, 3'd0, 1'b1, lat);
        chk("hold_lat", 64'(lat), 64'd1);
        chk("hold_res", 64'(res8), 64'h30);
        #1 rst8 = 1'b1;
        #1;
        chk1("rsthold_ov", ov8, 1'b0);
        chk("rsthold_res", 64'(res8), 64'h0);
        chk1("rsthold_zf", zf8, 1'b1);
        chk1("rsthold_ir", ir8, 1'b1);
        @(negedge clk); rst8 = 1'b0;
        issue8(3'b011, 8'h0F, 8'hFF, 3'd0, 1'b1, lat);
        chk("postrsth_lat", 64'(lat), 64'd1);
        chk8("postrsth", 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        release8("postrsth");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
